// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: segment bit positions, the active-low hex font
// and the output polarity helper.
package seg7_pkg;

  localparam int unsigned SegA  = 0;
  localparam int unsigned SegB  = 1;
  localparam int unsigned SegC  = 2;
  localparam int unsigned SegD  = 3;
  localparam int unsigned SegE  = 4;
  localparam int unsigned SegF  = 5;
  localparam int unsigned SegG  = 6;
  localparam int unsigned SegDp = 7;

  // Index 0 is the rightmost (least significant) entry; dp bit is always off here.
  localparam logic [15:0][7:0] Font = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [7:0] seg_polarity(input logic [7:0] seg_low, input bit active_low);
    return active_low ? seg_low : ~seg_low;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Host-side control bundle of the scanning display driver: per-digit content, update
// strobe and live brightness.
interface seg7_scan_driver_if #(
  parameter int unsigned DIGITS   = 6,
  parameter int unsigned BRIGHT_W = 4
);
  logic [DIGITS-1:0][3:0] data;
  logic [DIGITS-1:0]      dp;
  logic [DIGITS-1:0]      blank;
  logic                   lz_en;
  logic                   update;
  logic [BRIGHT_W-1:0]    brightness;

  modport master (output data, dp, blank, lz_en, update, brightness);
  modport slave  (input  data, dp, blank, lz_en, update, brightness);
endinterface

// File: rtl/seg7_digit.sv
// Combinational hex nibble to active-low segment decoder; dp (bit 7) is left inactive.
module seg7_digit
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);
  logic [7:0] glyph;

  assign glyph = Font[nibble];
  assign seg   = {1'b1, glyph[SegG], glyph[SegF], glyph[SegE], glyph[SegD],
                  glyph[SegC], glyph[SegB], glyph[SegA]};
endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver with frame-synchronous content update,
// leading-zero suppression, PWM brightness and anode dead time.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS         = 6,
  parameter int unsigned SCAN_DIV       = 1024,
  parameter int unsigned BRIGHT_W       = 4,
  parameter int unsigned DEAD           = 2,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  seg7_scan_driver_if.slave   host,
  output logic [7:0]          seg,
  output logic [DIGITS-1:0]   an,
  output logic                frame_done
);

  localparam int unsigned CntW = $clog2(SCAN_DIV);
  localparam int unsigned IdxW = $clog2(DIGITS);

  localparam logic [7:0]        SegOff = seg_polarity(8'hFF, SEG_ACTIVE_LOW);
  localparam logic [DIGITS-1:0] AnOff  = AN_ACTIVE_LOW ? '1 : '0;

  logic [CntW-1:0] cnt_q;
  logic [IdxW-1:0] idx_q;
  logic            frame_last;

  logic [DIGITS-1:0][3:0] stg_data_q, act_data_q;
  logic [DIGITS-1:0]      stg_dp_q, act_dp_q;
  logic [DIGITS-1:0]      stg_blank_q, act_blank_q;
  logic                   stg_lz_q, act_lz_q;

  logic [DIGITS-1:0] supp;
  logic              run;
  logic [3:0]        sel_nib;
  logic [7:0]        font_seg;
  logic [7:0]        seg_low;
  logic              pwm_on;
  logic [DIGITS-1:0] an_onehot;
  logic [7:0]        seg_d;
  logic [DIGITS-1:0] an_d;

  assign frame_last = (cnt_q == CntW'(SCAN_DIV - 1)) && (idx_q == IdxW'(DIGITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else if (cnt_q == CntW'(SCAN_DIV - 1)) begin
      cnt_q <= '0;
      idx_q <= (idx_q == IdxW'(DIGITS - 1)) ? '0 : idx_q + IdxW'(1);
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  // Staging follows every update; the active copy only changes at the frame boundary,
  // taking a same-cycle update directly so it is not lost for a whole frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_data_q  <= '0;
      stg_dp_q    <= '0;
      stg_blank_q <= '1;
      stg_lz_q    <= 1'b0;
      act_data_q  <= '0;
      act_dp_q    <= '0;
      act_blank_q <= '1;
      act_lz_q    <= 1'b0;
    end else begin
      if (host.update) begin
        stg_data_q  <= host.data;
        stg_dp_q    <= host.dp;
        stg_blank_q <= host.blank;
        stg_lz_q    <= host.lz_en;
      end
      if (frame_last) begin
        act_data_q  <= host.update ? host.data  : stg_data_q;
        act_dp_q    <= host.update ? host.dp    : stg_dp_q;
        act_blank_q <= host.update ? host.blank : stg_blank_q;
        act_lz_q    <= host.update ? host.lz_en : stg_lz_q;
      end
    end
  end

  // Suppression runs from the leftmost digit and stops at the first nonzero or dp digit.
  always_comb begin
    supp = '0;
    run  = act_lz_q;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      run     = run && (act_data_q[i] == 4'h0) && !act_dp_q[i];
      supp[i] = run;
    end
  end

  assign sel_nib = act_data_q[idx_q];

  seg7_digit u_digit (
    .nibble (sel_nib),
    .seg    (font_seg)
  );

  always_comb begin
    seg_low        = font_seg;
    seg_low[SegDp] = ~act_dp_q[idx_q];
    if (act_blank_q[idx_q] || supp[idx_q]) begin
      seg_low = 8'hFF;
    end
    seg_d = seg_polarity(seg_low, SEG_ACTIVE_LOW);
  end

  always_comb begin
    pwm_on    = (cnt_q >= CntW'(DEAD)) &&
                ((&host.brightness) || (cnt_q[BRIGHT_W-1:0] < host.brightness));
    an_onehot = pwm_on ? (DIGITS'(1) << idx_q) : '0;
    an_d      = AN_ACTIVE_LOW ? ~an_onehot : an_onehot;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= SegOff;
      an         <= AnOff;
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_d;
      an         <= an_d;
      frame_done <= frame_last;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: 4 digits, 16-cycle slots, 2 dead cycles.
module tb_seg7_scan_driver;
  import seg7_pkg::*;

  localparam int Digits  = 4;
  localparam int ScanDiv = 16;
  localparam int BrightW = 4;
  localparam int Dead    = 2;
  localparam int Frame   = Digits * ScanDiv;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] seg;
  logic [3:0] an;
  logic       frame_done;

  int errors = 0;
  int checks = 0;

  logic [7:0] cap_seg [Frame];
  logic [3:0] cap_an  [Frame];
  logic       cap_fd  [Frame];

  seg7_scan_driver_if #(.DIGITS(Digits), .BRIGHT_W(BrightW)) host ();

  seg7_scan_driver #(
    .DIGITS         (Digits),
    .SCAN_DIV       (ScanDiv),
    .BRIGHT_W       (BrightW),
    .DEAD           (Dead),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .host       (host),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Expected anode pattern for output cycle k of a frame (k = idx*16 + cnt).
  function automatic logic [3:0] exp_an(input int k, input logic [3:0] bright);
    int c;
    logic [3:0] r;
    c = k % ScanDiv;
    r = 4'hF;
    if (c >= Dead && (bright == 4'hF || c < int'(bright))) r[k / ScanDiv] = 1'b0;
    return r;
  endfunction

  task automatic do_update(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b,
                           input logic lz);
    @(negedge clk);
    host.data   = d;
    host.dp     = p;
    host.blank  = b;
    host.lz_en  = lz;
    host.update = 1'b1;
    @(posedge clk);
    #1 host.update = 1'b0;
  endtask

  task automatic wait_frame(input string name);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 3 * Frame && !seen; n++) begin
      @(negedge clk);
      if (frame_done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s frame_done timeout: got none within %0d cycles, want a pulse", name,
               3 * Frame);
    end
  endtask

  // Samples one frame of outputs; optionally injects an update of upd_data at cycle upd_at.
  task automatic capture_frame(input int upd_at, input logic [15:0] upd_data);
    for (int k = 0; k < Frame; k++) begin
      @(negedge clk);
      if (host.update) host.update = 1'b0;
      cap_seg[k] = seg;
      cap_an[k]  = an;
      cap_fd[k]  = frame_done;
      if (k == upd_at) begin
        host.data   = upd_data;
        host.update = 1'b1;
      end
    end
  endtask

  task automatic test_reset;
    host.data = '0; host.dp = '0; host.blank = '0; host.lz_en = 1'b0;
    host.update = 1'b0; host.brightness = 4'h0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks += 3;
    if (an !== 4'hF) begin errors++; $display("FAIL reset an: got %h want f", an); end
    if (seg !== 8'hFF) begin errors++; $display("FAIL reset seg: got %h want ff", seg); end
    if (frame_done !== 1'b0) begin
      errors++; $display("FAIL reset frame_done: got %b want 0", frame_done);
    end
    rst_n = 1'b1;
    for (int f = 0; f < 3; f++) begin
      capture_frame(-1, '0);
      for (int k = 0; k < Frame; k++) begin
        checks += 3;
        if (cap_seg[k] !== 8'hFF) begin
          errors++; $display("FAIL reset_dark seg f=%0d k=%0d: got %h want ff", f, k, cap_seg[k]);
        end
        if (cap_an[k] !== 4'hF) begin
          errors++; $display("FAIL reset_dark an f=%0d k=%0d: got %h want f", f, k, cap_an[k]);
        end
        if (cap_fd[k] !== (k == Frame - 1)) begin
          errors++;
          $display("FAIL reset_dark frame_done f=%0d k=%0d: got %b want %b", f, k, cap_fd[k],
                   k == Frame - 1);
        end
      end
    end
  endtask

  task automatic test_digits;
    logic [31:0] exp_segs [2];
    host.brightness = 4'hF;
    exp_segs[0] = 32'hF9A4B099;
    exp_segs[1] = 32'hF9A4FF99;
    for (int t = 0; t < 2; t++) begin
      do_update(16'h1234, 4'b0000, (t == 1) ? 4'b0010 : 4'b0000, 1'b0);
      wait_frame("digits");
      capture_frame(-1, '0);
      for (int k = 0; k < Frame; k++) begin
        checks += 2;
        if (cap_seg[k] !== exp_segs[t][(k / ScanDiv) * 8 +: 8]) begin
          errors++;
          $display("FAIL digits seg t=%0d k=%0d: got %h want %h", t, k, cap_seg[k],
                   exp_segs[t][(k / ScanDiv) * 8 +: 8]);
        end
        if (cap_an[k] !== exp_an(k, 4'hF)) begin
          errors++;
          $display("FAIL digits an t=%0d k=%0d: got %h want %h", t, k, cap_an[k],
                   exp_an(k, 4'hF));
        end
      end
    end
  endtask

  task automatic test_lz;
    logic [31:0] exp_segs [2];
    exp_segs[0] = 32'hFFFF92C0;
    exp_segs[1] = 32'hFF4092C0;
    for (int t = 0; t < 2; t++) begin
      do_update(16'h0050, (t == 1) ? 4'b0100 : 4'b0000, 4'b0000, 1'b1);
      wait_frame("lz");
      capture_frame(-1, '0);
      for (int k = 0; k < Frame; k++) begin
        checks++;
        if (cap_seg[k] !== exp_segs[t][(k / ScanDiv) * 8 +: 8]) begin
          errors++;
          $display("FAIL lz seg t=%0d k=%0d: got %h want %h", t, k, cap_seg[k],
                   exp_segs[t][(k / ScanDiv) * 8 +: 8]);
        end
      end
    end
  endtask

  task automatic test_brightness;
    logic [3:0] levels [2];
    levels[0] = 4'h4;
    levels[1] = 4'h0;
    for (int t = 0; t < 2; t++) begin
      host.brightness = levels[t];
      wait_frame("brightness");
      capture_frame(-1, '0);
      for (int k = 0; k < Frame; k++) begin
        checks++;
        if (cap_an[k] !== exp_an(k, levels[t])) begin
          errors++;
          $display("FAIL brightness an b=%0d k=%0d: got %h want %h", levels[t], k, cap_an[k],
                   exp_an(k, levels[t]));
        end
      end
    end
    host.brightness = 4'hF;
  endtask

  task automatic test_back_to_back;
    wait_frame("back_to_back");
    do_update(16'h5555, 4'b0000, 4'b0000, 1'b0);
    do_update(16'hAAAA, 4'b0000, 4'b0000, 1'b0);
    wait_frame("back_to_back");
    capture_frame(-1, '0);
    for (int k = 0; k < Frame; k++) begin
      checks++;
      if (cap_seg[k] !== 8'h88) begin
        errors++; $display("FAIL back_to_back seg k=%0d: got %h want 88", k, cap_seg[k]);
      end
    end
  endtask

  task automatic test_tear;
    do_update(16'h1111, 4'b0000, 4'b0000, 1'b0);
    wait_frame("tear");
    capture_frame(20, 16'hAAAA);
    for (int k = 0; k < Frame; k++) begin
      checks += 2;
      if (cap_seg[k] !== 8'hF9) begin
        errors++; $display("FAIL tear old_frame seg k=%0d: got %h want f9", k, cap_seg[k]);
      end
      if (cap_fd[k] !== (k == Frame - 1)) begin
        errors++;
        $display("FAIL tear frame_done k=%0d: got %b want %b", k, cap_fd[k], k == Frame - 1);
      end
    end
    capture_frame(-1, '0);
    for (int k = 0; k < Frame; k++) begin
      checks++;
      if (cap_seg[k] !== 8'h88) begin
        errors++; $display("FAIL tear new_frame seg k=%0d: got %h want 88", k, cap_seg[k]);
      end
    end
  endtask

  task automatic test_reset_mid;
    wait_frame("reset_mid");
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks += 3;
    if (an !== 4'hF) begin errors++; $display("FAIL reset_mid async an: got %h want f", an); end
    if (seg !== 8'hFF) begin
      errors++; $display("FAIL reset_mid async seg: got %h want ff", seg);
    end
    if (frame_done !== 1'b0) begin
      errors++; $display("FAIL reset_mid async frame_done: got %b want 0", frame_done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    capture_frame(-1, '0);
    for (int k = 0; k < Frame; k++) begin
      checks += 3;
      if (cap_seg[k] !== 8'hFF) begin
        errors++; $display("FAIL reset_mid seg k=%0d: got %h want ff", k, cap_seg[k]);
      end
      if (cap_an[k] !== exp_an(k, 4'hF)) begin
        errors++;
        $display("FAIL reset_mid an k=%0d: got %h want %h", k, cap_an[k], exp_an(k, 4'hF));
      end
      if (cap_fd[k] !== (k == Frame - 1)) begin
        errors++;
        $display("FAIL reset_mid frame_done k=%0d: got %b want %b", k, cap_fd[k],
                 k == Frame - 1);
      end
    end
  endtask

  initial begin
    test_reset;
    test_digits;
    test_lz;
    test_brightness;
    test_back_to_back;
    test_tear;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed seven-segment display driver: the parametrised successor to the static per-digit decoder. Drives a shared segment bus plus one anode enable per digit, scanning digits in turn. Adds tear-free frame-synchronous data update, per-digit blanking and decimal points, leading-zero suppression, PWM brightness and anti-ghosting dead time. Sits between the board-level register file/debug counters and the display pins.

## Interface
- `DIGITS`, 6: number of digits scanned (≥2).
- `SCAN_DIV`, 1024: clock cycles per digit slot; must be ≥ 2^`BRIGHT_W` and > `DEAD`.
- `BRIGHT_W`, 4: brightness control width.
- `DEAD`, 2: cycles at the start of each slot with all anodes off.
- `SEG_ACTIVE_LOW`, 1: segment outputs drive 0 to light.
- `AN_ACTIVE_LOW`, 1: anode outputs drive 0 to enable.

Ports:
- `clk` in 1: the single clock; all state on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `data` in `[DIGITS-1:0][3:0]`: hex nibble per digit, index 0 = rightmost.
- `dp` in `DIGITS`: decimal point request per digit.
- `blank` in `DIGITS`: force digit dark (segments and dp).
- `lz_en` in 1: enable leading-zero suppression.
- `update` in 1: one-cycle strobe; captures `data`, `dp`, `blank`, `lz_en`.
- `brightness` in `BRIGHT_W`: duty; 0 = off, all-ones = full-on.
- `seg` out 8: `{dp,g,f,e,d,c,b,a}`, shared across digits.
- `an` out `DIGITS`: one-hot (or none) anode enable.
- `frame_done` out 1: one-cycle pulse at the last cycle of each frame.

## Operation
- Slot counter `cnt` runs 0..`SCAN_DIV`-1, then wraps to 0. `idx` advances on wrap: 0→1→…→`DIGITS`-1→0.
- Staging register captures the inputs on `update`. The active register loads from staging on the `frame_done` cycle only. A frame therefore never mixes old and new values.
- `update` in the same cycle as `frame_done`: the new inputs go directly into the active register. Multiple `update`s within one frame: the last one wins.
- Leading-zero suppression, evaluated on the active register:
  - Scan from digit `DIGITS`-1 down to 1.
  - A digit is suppressed while its nibble is 0, its `dp` is 0, and every higher digit is suppressed.
  - Digit 0 is never suppressed.
  - A digit with `dp` set ends suppression: "0.5" shows the 0.
- A dark digit (blanked or suppressed) drives all segments inactive, including dp.
- Font: 0–F, standard active-low encoding (0=0xC0, 1=0xF9, 8=0x80, F=0x8E). Bit 7 is driven by `dp`. Outputs are inverted when `SEG_ACTIVE_LOW`=0.
- Anode for `idx` is active iff both hold:
  - `cnt` ≥ `DEAD`;
  - `brightness` is all-ones, or `cnt[BRIGHT_W-1:0]` < `brightness`.
- Otherwise no anode is active. Polarity follows `AN_ACTIVE_LOW`.
- `brightness` is sampled live, not staged.

## Timing
- Reset values:
  - `cnt`=0, `idx`=0.
  - Staging and active registers all 0 with `blank` all-ones, so the display is dark until the first `update`.
  - `seg` = all inactive; `an` = all inactive; `frame_done`=0.
- `seg`, `an` and `frame_done` are registered: 1-cycle latency from `cnt`/`idx`.
- Frame period = `DIGITS`·`SCAN_DIV` cycles.
- `frame_done` is high for one cycle each frame, in the cycle when `cnt`=`SCAN_DIV`-1 and `idx`=`DIGITS`-1 (registered version).
- `update` → visible output, worst case: one full frame + 1 cycle + `DEAD`.
- Deassertion of `rst_n` mid-frame restarts at `idx` 0, `cnt` 0, display dark. Assertion forces outputs inactive immediately (asynchronous).
- `seg` changes only while all anodes are inactive; this is guaranteed when `DEAD` ≥ 1.

## Structure
- Shared package `seg7_pkg`:
  - segment bit index constants (A..G, DP);
  - 16-entry active-low font constant;
  - function for the polarity inversion.
- Reuse `seg7_digit` as the single sub-module: one instance decodes the selected nibble. The top level overrides bit 7 and handles blanking.
- Top level holds the counters, staging/active registers, suppression logic, PWM compare and output registers.

## Test plan
Bench configuration: `DIGITS`=4, `SCAN_DIV`=16, `BRIGHT_W`=4, `DEAD`=2, both polarities active-low.

- Reset, no `update` → `an`=4'hF and `seg`=8'hFF for 3 frames; `frame_done` pulses every 64 cycles.
- `update` with data=0x1234, `dp`=0, `blank`=0, `brightness`=F → next frame digit 0 `seg`=0x99, digit 3 `seg`=0xF9. Each `an` low for 14 cycles after 2 dead cycles.
- `lz_en`=1, data=0x0050, `dp`=0 → digits 3 and 2 dark, digit 1 shows 0x92, digit 0 shows 0xC0. Then set `dp`[2]=1 → digit 2 shows 0x40.
- `brightness`=4 → each anode active only for `cnt` 2,3 of each slot. `brightness`=0 → `an` stays 4'hF.
- `update` mid-frame with data=0xAAAA after 0x1111 → remainder of the frame still shows 0xF9. 0x88 appears from the next frame.
- `rst_n` pulsed low mid-slot → `an`/`seg` go inactive the same cycle; scan restarts at digit 0 dark; `frame_done` is 64 cycles after release.
